// File: rtl/syscall_pkg.sv
// Shared types and default service codes for the syscall unit.
package syscall_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STALL  = 2'd2
  } sc_state_t;

  localparam logic [31:0] HALT_CODE_DEF  = 32'd10;
  localparam logic [31:0] PRINT_CODE_DEF = 32'd34;

endpackage

// File: rtl/syscall_fifo.sv
// Print queue: DEPTH-entry circular FIFO, simultaneous push/pop allowed when full.
// The head output holds the last popped value while the queue is empty.
module syscall_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [DATA_W-1:0] last_head;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? last_head : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_head <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/syscall_unit.sv
// Syscall service unit: halt/resume, buffered print queue with pipeline stall.
// Define SYSCALL_CNT_EN to build the accepted-syscall counter (sc_count).
import syscall_pkg::*;

module syscall_unit #(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] HALT_CODE  = HALT_CODE_DEF,
  parameter logic [31:0] PRINT_CODE = PRINT_CODE_DEF
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              syscall,
  input  logic              go,
  input  logic [31:0]       v0,
  input  logic [DATA_W-1:0] a0,
  output logic              halt,
  output logic              stall,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [DATA_W-1:0] disp_last,
  output logic [31:0]       sc_count
);

  sc_state_t         state, state_n;
  logic [DATA_W-1:0] hold, hold_n;
  logic [DATA_W-1:0] push_data;
  logic              push, pop, full, empty;

  assign disp_valid = ~empty;
  assign pop        = disp_valid & disp_ready;
  assign halt       = (state == ST_HALTED);
  assign stall      = (state == ST_STALL);

  syscall_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .CLR       (CLR),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (disp_data)
  );

  always_comb begin
    state_n   = state;
    hold_n    = hold;
    push      = 1'b0;
    push_data = a0;
    case (state)
      ST_RUN: begin
        if (syscall) begin
          if (v0 == HALT_CODE) begin
            state_n = ST_HALTED;
          end else if (v0 == PRINT_CODE) begin
            // A pop this cycle frees the slot, so a full queue need not stall.
            if (!full || pop) begin
              push = 1'b1;
            end else begin
              hold_n  = a0;
              state_n = ST_STALL;
            end
          end
        end
      end
      ST_HALTED: if (go) state_n = ST_RUN;
      ST_STALL: begin
        push_data = hold;
        if (pop) begin
          push    = 1'b1;
          state_n = ST_RUN;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state     <= ST_RUN;
      hold      <= '0;
      disp_last <= '0;
    end else begin
      state <= state_n;
      hold  <= hold_n;
      if (push) disp_last <= push_data;
    end
  end

`ifdef SYSCALL_CNT_EN
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR)                           sc_count <= '0;
    else if (syscall && state == ST_RUN) sc_count <= sc_count + 32'd1;
  end
`else
  assign sc_count = '0;
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Scoreboard bench for syscall_unit: queue-based reference model plus pop monitor.
module tb_syscall_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        CLR = 1'b1;
  logic        syscall = 1'b0, go = 1'b0, disp_ready = 1'b0;
  logic [31:0] v0 = '0, a0 = '0;
  logic        halt, stall, disp_valid;
  logic [31:0] disp_data, disp_last, sc_count;

  int checks = 0;
  int failures = 0;

  syscall_unit #(.DATA_W(32), .DEPTH(DEPTH), .HALT_CODE(32'd10), .PRINT_CODE(32'd34)) dut (
    .clk(clk), .CLR(CLR), .syscall(syscall), .go(go), .v0(v0), .a0(a0),
    .halt(halt), .stall(stall), .disp_data(disp_data), .disp_valid(disp_valid),
    .disp_ready(disp_ready), .disp_last(disp_last), .sc_count(sc_count)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = running, 1 = halted, 2 = waiting for room
  int          mode = 0;
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] hold_m = '0, last_push = '0, last_pop = '0, cnt = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef SYSCALL_CNT_EN
    return cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_state();
    chk("halt", {31'd0, halt}, {31'd0, mode == 1});
    chk("stall", {31'd0, stall}, {31'd0, mode == 2});
    chk("disp_valid", {31'd0, disp_valid}, {31'd0, mq.size() > 0});
    chk("disp_last", disp_last, last_push);
    chk("sc_count", sc_count, exp_count());
    if (mq.size() == 0) chk("disp_data_idle", disp_data, last_pop);
  endtask

  task automatic model_step(input bit sc, input logic [31:0] v, input logic [31:0] a,
                            input bit g, input bit r);
    bit          pop_m = r && (mq.size() > 0);
    bit          push_m = 1'b0;
    logic [31:0] pv = '0;
    case (mode)
      0: if (sc) begin
        cnt++;
        if (v == 32'd10) mode = 1;
        else if (v == 32'd34) begin
          if (mq.size() < DEPTH || pop_m) begin push_m = 1'b1; pv = a; end
          else begin hold_m = a; mode = 2; end
        end
      end
      1: if (g) mode = 0;
      default: if (pop_m) begin push_m = 1'b1; pv = hold_m; mode = 0; end
    endcase
    if (pop_m) last_pop = mq.pop_front();
    if (push_m) begin
      mq.push_back(pv);
      exp_q.push_back(pv);
      last_push = pv;
    end
  endtask

  task automatic cycle(input bit sc, input logic [31:0] v, input logic [31:0] a,
                       input bit g, input bit r);
    @(negedge clk);
    check_state();
    syscall = sc; v0 = v; a0 = a; go = g; disp_ready = r;
    model_step(sc, v, a, g, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    syscall = 0; go = 0; disp_ready = 0; v0 = '0; a0 = '0;
    #3 CLR = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_valid", {31'd0, disp_valid}, 32'd0);
    chk("rst_last", disp_last, 32'd0);
    chk("rst_data", disp_data, 32'd0);
    chk("rst_count", sc_count, 32'd0);
    mode = 0; mq.delete(); exp_q.delete();
    hold_m = '0; last_push = '0; last_pop = '0; cnt = '0;
    @(negedge clk);
    CLR = 1'b0;
  endtask

  // Monitor: inputs settle at negedge, so negedge+2 sees exactly the handshake
  // that completes at the following rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!CLR && disp_valid && disp_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", disp_data, 32'hxxxx_xxxx);
        end else begin
          chk("pop_data", disp_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    do_reset();
    // single print with consumer stalled
    cycle(1, 34, 32'h1234, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("first_head", disp_data, 32'h1234);
    cycle(0, 0, 0, 0, 1);
    // fill to overflow then release one slot
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1, 34, 32'(i), 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1);
    // halt, ignored print while halted, stray go, resume
    cycle(1, 10, 0, 0, 0);
    cycle(1, 34, 32'hdead, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 7, 0, 0, 0);
    // full queue with simultaneous push and pop
    for (int i = 0; i < 4; i++) cycle(1, 34, 32'h100 + 32'(i), 0, 0);
    cycle(1, 34, 32'h200, 0, 1);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
    // reset while stalled discards held value and queue
    for (int i = 0; i < 5; i++) cycle(1, 34, 32'h300 + 32'(i), 0, 0);
    cycle(0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      int          sel = $urandom_range(0, 9);
      logic [31:0] v = (sel < 4) ? 32'd34 : (sel == 4) ? 32'd10 : (32'h100 | $urandom());
      if (n == 400) do_reset();
      cycle($urandom_range(0, 1) == 1, v, $urandom(), $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) != 0);
    end
    cycle(0, 0, 0, 1, 0);
    @(negedge clk);
    check_state();
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
